// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: finds a programmable PAT_W-bit pattern in a qualified
// bit stream, then emits a fixed-length pulse followed by a holdoff window.
module seq_pattern_detector #(
  parameter int unsigned      PAT_W     = 2,
  parameter logic [PAT_W-1:0] PATTERN   = 2'b01,
  parameter int unsigned      PULSE_LEN = 2,
  parameter int unsigned      HOLDOFF   = 2,
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_in,
  input  logic             in_valid,
  input  logic             overlap,
  output logic             y_out,
  output logic             busy,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned HIST_W  = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam int unsigned CAT_W   = HIST_W + 1;
  localparam int unsigned FILL_W  = $clog2(PAT_W) + 1;
  localparam int unsigned T_MAX   = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int unsigned T_MAX1  = (T_MAX > 1) ? T_MAX : 1;
  localparam int unsigned TIMER_W = $clog2(T_MAX1) + 1;

  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [TIMER_W-1:0] PULSE_T0  = TIMER_W'(PULSE_LEN - 1);
  localparam logic [TIMER_W-1:0] HOLD_T0   = TIMER_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  // For PAT_W=1 the history bit is unused and is masked out of the compare.
  localparam logic [CAT_W-1:0]   CMP_MASK  = (PAT_W == 1) ? CAT_W'(1) : {CAT_W{1'b1}};
  localparam logic [CAT_W-1:0]   PAT_EXT   = CAT_W'(PATTERN);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_PULSE  = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               y_q, y_d;
  logic               busy_q, busy_d;

  logic [CAT_W-1:0]   cat_s;
  logic [HIST_W-1:0]  hist_shift_s;
  logic [FILL_W-1:0]  fill_inc_s;
  logic [CNT_W-1:0]   count_inc_s;
  logic               match_s;

  assign cat_s        = {hist_q, x_in};
  assign hist_shift_s = cat_s[HIST_W-1:0];
  assign fill_inc_s   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign count_inc_s  = (&count_q) ? count_q : count_q + CNT_W'(1);
  assign match_s      = (fill_q == FILL_FULL) && ((cat_s & CMP_MASK) == PAT_EXT);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_SEARCH;
      hist_q  <= {HIST_W{1'b0}};
      fill_q  <= {FILL_W{1'b0}};
      timer_q <= {TIMER_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      timer_q <= timer_d;
      count_q <= count_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    timer_d = timer_q;
    count_d = count_q;
    case (state_q)
      S_SEARCH: begin
        if (in_valid && match_s) begin
          state_d = S_PULSE;
          timer_d = PULSE_T0;
          count_d = count_inc_s;
          if (overlap) begin
            hist_d = hist_shift_s;
            fill_d = fill_inc_s;
          end else begin
            fill_d = {FILL_W{1'b0}};
          end
        end else if (in_valid) begin
          hist_d = hist_shift_s;
          fill_d = fill_inc_s;
        end else begin
          hist_d = hist_q;
        end
      end
      S_PULSE, S_HOLD: begin
        if (timer_q != {TIMER_W{1'b0}}) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if ((state_q == S_PULSE) && (HOLDOFF > 0)) begin
          state_d = S_HOLD;
          timer_d = HOLD_T0;
        end else begin
          state_d = S_SEARCH;
          timer_d = {TIMER_W{1'b0}};
        end
        // In overlap mode bits keep flowing into history while busy, never matching.
        if (in_valid && overlap) begin
          hist_d = hist_shift_s;
          fill_d = fill_inc_s;
        end else begin
          fill_d = fill_q;
        end
      end
      default: begin
        state_d = S_SEARCH;
        timer_d = {TIMER_W{1'b0}};
      end
    endcase
  end

  // Output decode of the upcoming state, registered alongside it
  always_comb begin
    y_d    = (state_d == S_PULSE);
    busy_d = (state_d != S_SEARCH);
  end

  assign y_out       = y_q;
  assign busy        = busy_q;
  assign match_count = count_q;

endmodule
